// File: rtl/lsr_byte_collector.sv
// Collects 4-bit nibbles from an upstream left shift register into bytes and buffers them in a FIFO.
// Optional dropped-byte counter port enabled by defining LSR_COLL_DROP_CNT_EN.
module lsr_byte_collector #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lsr_q,
  input  logic       lsr_shift,
  input  logic       lsr_ld,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  input  logic       ovf_clr
`ifdef LSR_COLL_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } phase_e;

  logic [1:0]    bit_cnt_q, bit_cnt_d;
  logic          cap_pend_q, cap_pend_d;
  phase_e        phase_q, phase_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic capture;
  logic push_req;
  logic push_ok;
  logic pop;
  logic full;
  logic drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      cap_pend_q <= 1'b0;
      phase_q    <= HI;
      hi_nib_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      cap_pend_q <= cap_pend_d;
      phase_q    <= phase_d;
      hi_nib_q   <= hi_nib_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // A load discards everything in flight; a wrap on the 4th shift arms a capture for the next edge.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    cap_pend_d = 1'b0;
    phase_d    = phase_q;
    hi_nib_d   = hi_nib_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    capture  = cap_pend_q && !lsr_ld;
    push_req = capture && (phase_q == LO);
    pop      = out_valid && out_ready;
    full     = (count_q == CW'(DEPTH));
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    if (lsr_ld) begin
      bit_cnt_d = '0;
      phase_d   = HI;
    end else begin
      if (lsr_shift) begin
        bit_cnt_d  = bit_cnt_q + 2'd1;
        cap_pend_d = (bit_cnt_q == 2'd3);
      end
      if (capture) begin
        case (phase_q)
          HI: begin
            hi_nib_d = lsr_q;
            phase_d  = LO;
          end
          LO: phase_d = HI;
          default: phase_d = HI;
        endcase
      end
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

    if (drop) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Storage is reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= {hi_nib_q, lsr_q};
    end
  end

`ifdef LSR_COLL_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr) drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_lsr_byte_collector.sv
// Scoreboard bench for lsr_byte_collector: expected bytes are queued as stimulus is driven
// and compared as the DUT hands them out.
module tb_lsr_byte_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] lsr_q = '0;
  logic       lsr_shift = 1'b0;
  logic       lsr_ld = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;
`ifdef LSR_COLL_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int assertCount = 0;
  int failCount = 0;
  logic [7:0] sb[$];

  lsr_byte_collector #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .lsr_q(lsr_q),
    .lsr_shift(lsr_shift),
    .lsr_ld(lsr_ld),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
`ifdef LSR_COLL_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Inputs only change 1 time unit after a rising edge, so a falling-edge sample predicts the handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) checkOutput("unexpectedByte", {24'h0, out_data}, 32'hFFFF_FFFF);
      else checkOutput("byte", {24'h0, out_data}, {24'h0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift4();
    for (int i = 0; i < 4; i++) begin
      lsr_shift = 1'b1;
      lsr_q = 4'($urandom);
      tick();
    end
    lsr_shift = 1'b0;
  endtask

  task automatic capture(input logic [3:0] n);
    lsr_shift = 1'b0;
    lsr_q = n;
    tick();
  endtask

  task automatic applyStimulus(input logic [3:0] hi, input logic [3:0] lo, input bit expectKept);
    if (expectKept) sb.push_back({hi, lo});
    shift4();
    capture(hi);
    shift4();
    capture(lo);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    checkOutput("drainEmpty", sb.size(), 0);
    checkOutput("drainValid", {31'h0, out_valid}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstValid", {31'h0, out_valid}, 0);
    checkOutput("rstData", {24'h0, out_data}, 0);
    checkOutput("rstOvf", {31'h0, ovf}, 0);
`ifdef LSR_COLL_DROP_CNT_EN
    checkOutput("rstDropCnt", {24'h0, drop_cnt}, 0);
`endif
    rst = 1'b1;
    tick();

    $display("[TB] basic byte A5");
    out_ready = 1'b1;
    sb.push_back(8'hA5);
    shift4();
    capture(4'hA);
    shift4();
    checkOutput("a5NotYetValid", {31'h0, out_valid}, 0);
    capture(4'h5);
    checkOutput("a5Valid", {31'h0, out_valid}, 1);
    checkOutput("a5Data", {24'h0, out_data}, 32'hA5);
    drain();

    $display("[TB] load discards partial nibble");
    shift4();
    capture(4'h3);
    for (int i = 0; i < 2; i++) begin
      lsr_shift = 1'b1;
      tick();
    end
    lsr_shift = 1'b0;
    lsr_ld = 1'b1;
    tick();
    lsr_ld = 1'b0;
    applyStimulus(4'hC, 4'h9, 1'b1);
    drain();

    $display("[TB] overflow with consumer stalled");
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) applyStimulus(4'h0, 4'(b), b <= 4);
    checkOutput("fullOvf", {31'h0, ovf}, 1);
    checkOutput("fullValid", {31'h0, out_valid}, 1);
`ifdef LSR_COLL_DROP_CNT_EN
    checkOutput("fullDropCnt", {24'h0, drop_cnt}, 1);
`endif
    out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("popEveryCycle", {31'h0, out_valid}, 0);
    checkOutput("popSbEmpty", sb.size(), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovfCleared", {31'h0, ovf}, 0);
`ifdef LSR_COLL_DROP_CNT_EN
    checkOutput("dropCntCleared", {24'h0, drop_cnt}, 0);
`endif

    $display("[TB] full FIFO push with simultaneous pop");
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) applyStimulus(4'h0, 4'(b), 1'b1);
    sb.push_back(8'h05);
    shift4();
    capture(4'h0);
    shift4();
    out_ready = 1'b1;
    capture(4'h5);
    out_ready = 1'b0;
    checkOutput("pushPopOvf", {31'h0, ovf}, 0);
    drain();

    $display("[TB] load and shift while capture pending");
    shift4();
    capture(4'h2);
    shift4();
    lsr_shift = 1'b1;
    lsr_ld = 1'b1;
    lsr_q = 4'hF;
    tick();
    lsr_shift = 1'b0;
    lsr_ld = 1'b0;
    applyStimulus(4'h7, 4'hE, 1'b1);
    drain();

    $display("[TB] ovf_clr coincident with drop");
    out_ready = 1'b0;
    applyStimulus(4'h1, 4'h1, 1'b1);
    applyStimulus(4'h2, 4'h2, 1'b1);
    applyStimulus(4'h3, 4'h3, 1'b1);
    applyStimulus(4'h4, 4'h4, 1'b1);
    shift4();
    capture(4'h5);
    shift4();
    ovf_clr = 1'b1;
    capture(4'h5);
    ovf_clr = 1'b0;
    checkOutput("clrDropOvf", {31'h0, ovf}, 1);
`ifdef LSR_COLL_DROP_CNT_EN
    checkOutput("clrDropCnt", {24'h0, drop_cnt}, 1);
`endif
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("clrAfterDrop", {31'h0, ovf}, 0);
    drain();

    $display("[TB] continuous shifting");
    out_ready = 1'b1;
    sb.push_back(8'hD4);
    sb.push_back(8'h6B);
    for (int k = 1; k <= 17; k++) begin
      lsr_shift = 1'b1;
      case (k)
        5: lsr_q = 4'hD;
        9: lsr_q = 4'h4;
        13: lsr_q = 4'h6;
        17: lsr_q = 4'hB;
        default: lsr_q = 4'($urandom);
      endcase
      tick();
    end
    lsr_shift = 1'b0;
    lsr_ld = 1'b1;
    tick();
    lsr_ld = 1'b0;
    drain();

    $display("[TB] asynchronous reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(4'h3, 4'hC, 1'b0);
    shift4();
    checkOutput("preRstValid", {31'h0, out_valid}, 1);
    rst = 1'b0;
    #1;
    checkOutput("asyncRstValid", {31'h0, out_valid}, 0);
    checkOutput("asyncRstData", {24'h0, out_data}, 0);
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    applyStimulus(4'h8, 4'h1, 1'b1);
    drain();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/lsr_byte_collector.md
# lsr_byte_collector

Downstream consumer of the 4-bit left shift register stage. It counts single-bit shifts into the register, captures the register's parallel output after every fourth shift, pairs consecutive nibbles into bytes (first nibble high, second nibble low), and buffers the bytes in a small FIFO with a valid/ready output handshake. A parallel-load event on the shift register discards any partial nibble or byte.

## Interface
- DEPTH, 4, FIFO entries; must be a power of two, 2..16
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- lsr_q  in  4  parallel output of the upstream shift register
- lsr_shift  in  1  high in a cycle where the upstream register performs a 1-bit shift at the coming edge
- lsr_ld  in  1  high in a cycle where the upstream register performs a parallel load at the coming edge
- out_data  out  8  FIFO head byte; {first nibble, second nibble}
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- ovf  out  1  sticky: a completed byte was dropped because the FIFO was full
- ovf_clr  in  1  synchronous clear of ovf
- drop_cnt  out  8  dropped-byte count; present only with LSR_COLL_DROP_CNT_EN

## Operation
- Internal state: bit_cnt (2 bits), cap_pend (1 bit), phase FSM {HI, LO}, hi_nib (4 bits), FIFO storage with rd/wr pointers and count.
- Reset values: bit_cnt=0, cap_pend=0, phase=HI, hi_nib=0, FIFO empty, out_valid=0, out_data=0, ovf=0, drop_cnt=0.
- Edge with lsr_ld=1: bit_cnt<=0, cap_pend<=0, phase<=HI. lsr_shift and any pending capture in the same cycle are ignored (load has priority, matching the upstream register).
- Edge with lsr_shift=1, lsr_ld=0: bit_cnt<=bit_cnt+1 (wraps 3->0). On the wrap, cap_pend<=1.
- Edge with cap_pend=1, lsr_ld=0: capture lsr_q and clear cap_pend (unless a new wrap sets it in the same edge; set has priority).
  - phase HI: hi_nib<=lsr_q, phase<=LO.
  - phase LO: byte={hi_nib, lsr_q}, push to FIFO, phase<=HI.
- Push when FIFO full: if out_valid&out_ready in the same cycle, the push is accepted and the count is unchanged. Otherwise the byte is dropped and ovf<=1.
- ovf_clr=1 clears ovf. A drop in the same cycle takes priority, so ovf stays 1.
- Pop: out_valid&out_ready advances the read pointer. Pointers wrap modulo DEPTH.
- out_data always shows the head entry. It is only meaningful while out_valid=1.

## Timing
- Shifts at edges E1..E4 set cap_pend at E4. The nibble is captured at E5 from lsr_q, which holds all four bits after E4.
- Byte latency: the push happens at the capture edge of the second nibble. out_valid rises in the following cycle if the FIFO was empty.
- Continuous shifting (lsr_shift held high) sustains one byte per 8 cycles. The capture of nibble N overlaps the shifts of nibble N+1.
- Full-throughput pop: a byte is accepted every cycle while out_valid=1 and out_ready=1.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Partial nibbles and bytes, and FIFO contents, are lost.

## Configuration
- LSR_COLL_DROP_CNT_EN defined: drop_cnt port exists. It increments on every dropped byte and saturates at 255. ovf_clr also clears drop_cnt; an increment in the same cycle loads 1.
- Not defined: drop_cnt port and its logic are absent. Only the sticky ovf reports drops.

## Test plan
- Reset, then 8 consecutive lsr_shift cycles with lsr_q=4'hA after the 4th shift and 4'h5 after the 8th -> out_data=8'hA5, out_valid=1 one cycle after the second capture edge.
- lsr_ld asserted after 6 shifts (first nibble 4'h3 captured), then 8 fresh shifts giving 4'hC, 4'h9 -> single byte 8'hC9. The partial 4'h3 never appears.
- out_ready=0 with DEPTH=4 and 5 bytes produced (8'h01..8'h05) -> FIFO holds 01..04, ovf=1, drop_cnt=1 (macro on). Popping yields 01,02,03,04 in order.
- FIFO full, and the 5th byte completes in a cycle with out_valid&out_ready=1 -> 01 popped, byte accepted, ovf stays 0.
- lsr_ld and lsr_shift both high in the cycle where cap_pend=1 -> no capture, bit_cnt=0, phase=HI.
- ovf_clr pulsed in the same cycle as a drop -> ovf remains 1; drop_cnt=1 (macro on).
